// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared state type and counter sizing for the key conditioner
package key_pkg;

  typedef enum logic [1:0] {
    S_UP,
    S_DOWN,
    S_REPEAT
  } key_state_t;

  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-flop sync, stability debounce, press/release/typematic FSM
module key_channel
  import key_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = cnt_width(RMAX);

  localparam logic            REL_LEVEL   = (ACTIVE_LOW != 0);
  localparam bit              REPEAT_EN   = (REPEAT_DELAY != 0);
  localparam logic [DW-1:0]   DB_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0]   DELAY_LAST  = RW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RW-1:0]   PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          held_q, held_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  key_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          p;
  logic          accept;

  always_comb begin
    sync1_d = key_in;
    sync2_d = sync1_q;
    p       = sync2_q ^ REL_LEVEL;

    // Any cycle that agrees with the accepted level restarts the stability count.
    accept = 1'b0;
    held_d = held_q;
    dcnt_d = dcnt_q;
    if (p == held_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DB_LAST) begin
      accept = 1'b1;
      held_d = p;
      dcnt_d = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end

    state_d   = state_q;
    rcnt_d    = rcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      S_UP: begin
        if (accept) begin
          state_d = S_DOWN;
          press_d = 1'b1;
          rcnt_d  = '0;
        end
      end
      S_DOWN: begin
        if (accept) begin
          state_d   = S_UP;
          release_d = 1'b1;
          rcnt_d    = '0;
        end else if (REPEAT_EN) begin
          if (rcnt_q == DELAY_LAST) begin
            state_d  = S_REPEAT;
            repeat_d = 1'b1;
            rcnt_d   = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        // A release landing on a repeat slot suppresses that repeat.
        if (accept) begin
          state_d   = S_UP;
          release_d = 1'b1;
          rcnt_d    = '0;
        end else if (rcnt_q == PERIOD_LAST) begin
          repeat_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_UP;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= REL_LEVEL;
      sync2_q   <= REL_LEVEL;
      held_q    <= 1'b0;
      dcnt_q    <= '0;
      state_q   <= S_UP;
      rcnt_q    <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      held_q    <= held_d;
      dcnt_q    <= dcnt_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - N independent debounced key channels with press/release/repeat pulses
module key_conditioner #(
  parameter int N_KEYS          = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .key_in        (key_in[i]),
      .held          (held[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed and random checks of key_conditioner against a history-based model
module tb_key_conditioner;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk;
  logic         reset;
  logic [N-1:0] key_in;
  logic [N-1:0] held, press_pulse, release_pulse, repeat_pulse;

  int errors = 0;
  int checks = 0;

  key_conditioner #(
    .N_KEYS          (N),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .key_in        (key_in),
    .held          (held),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pressed level is accepted once the last D synchronised samples all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_held, m_press, m_rel, m_rep;
  logic [D-1:0] m_hist [N];
  int           m_tpress [N];
  int           cyc = 0;

  task automatic model_edge();
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_held = '0;
      m_press = '0; m_rel = '0; m_rep = '0;
      for (int c = 0; c < N; c++) begin
        m_hist[c]   = '0;
        m_tpress[c] = 0;
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        logic acc;
        int   k;
        m_hist[c]  = {m_hist[c][D-2:0], m_s2[c]};
        acc        = (m_hist[c] == {D{~m_held[c]}});
        m_press[c] = acc && !m_held[c];
        m_rel[c]   = acc && m_held[c];
        if (acc) m_held[c] = ~m_held[c];
        if (m_press[c]) m_tpress[c] = cyc;
        k = cyc - m_tpress[c];
        m_rep[c] = !acc && m_held[c] && (k >= RD) && (((k - RD) % RP) == 0);
      end
      m_s2 = m_s1;
      m_s1 = ~key_in;
    end
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_held",    32'(held),          32'(m_held));
    chk("model_press",   32'(press_pulse),   32'(m_press));
    chk("model_release", 32'(release_pulse), 32'(m_rel));
    chk("model_repeat",  32'(repeat_pulse),  32'(m_rep));
  endtask

  initial begin
    bit got;
    reset  = 1'b1;
    key_in = '1;
    step();
    step();
    chk("reset_held",  32'(held),                                     32'd0);
    chk("reset_pulse", 32'(press_pulse | release_pulse | repeat_pulse), 32'd0);
    reset = 1'b0;
    step();

    // Press on key 0: accepted on the 6th edge, pulse lasts one cycle.
    key_in[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("press0_pulse", 32'(press_pulse[0]), 32'(i == 6));
      chk("press0_held",  32'(held[0]),        32'(i >= 6));
      chk("press0_other", 32'(held[3:1] | press_pulse[3:1]), 32'd0);
    end
    for (int i = 0; i < 12; i++) step();

    // Release key 0.
    key_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("release0_pulse", 32'(release_pulse[0]), 32'(i == 6));
      chk("release0_held",  32'(held[0]),          32'(i < 6));
    end

    // Bounce on key 1 never reaches the debounce threshold.
    begin
      int pat [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
        key_in[1] = pat[i][0];
        step();
        chk("bounce1_held", 32'(held[1] | press_pulse[1]), 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
        step();
        chk("bounce1_quiet", 32'(held[1] | press_pulse[1]), 32'd0);
      end
    end

    // Auto-repeat on key 2, then release on a repeat slot.
    key_in[2] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = press_pulse[2];
    end
    chk("press2_seen", 32'(got), 32'd1);
    for (int k = 1; k <= 31; k++) begin
      if (k == 26) key_in[2] = 1'b1;
      step();
      chk("repeat2_slot", 32'(repeat_pulse[2]),
          32'((k < 31) && (k >= RD) && (((k - RD) % RP) == 0)));
      chk("release2_slot", 32'(release_pulse[2]), 32'(k == 31));
    end
    for (int i = 0; i < 4; i++) step();

    // Keys 0 and 3 together, released independently.
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("simul_press", 32'(press_pulse & 4'b1001), 32'((i == 6) ? 4'b1001 : 4'b0000));
    end
    key_in[3] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("simul_rel3", 32'(release_pulse & 4'b1001), 32'((i == 6) ? 4'b1000 : 4'b0000));
    end
    key_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("simul_rel0", 32'(release_pulse & 4'b1001), 32'((i == 6) ? 4'b0001 : 4'b0000));
    end

    // Reset while key 2 is repeating; key still down afterwards reads as a fresh press.
    key_in[2] = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("pre_reset_held2", 32'(held[2]), 32'd1);
    reset = 1'b1;
    step();
    chk("midreset_held",  32'(held), 32'd0);
    chk("midreset_pulse", 32'(press_pulse | release_pulse | repeat_pulse), 32'd0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("post_reset_press2", 32'(press_pulse[2]), 32'(i == 6));
      chk("post_reset_norel",  32'(release_pulse), 32'd0);
    end
    key_in[2] = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Random bouncy pins.
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 9) == 0) key_in[c] = ~key_in[c];
      if (i == 500) reset = 1'b1;
      if (i == 502) reset = 1'b0;
      step();
      chk("rand_exclusive",
          32'((press_pulse & release_pulse) | (press_pulse & repeat_pulse) | (release_pulse & repeat_pulse)),
          32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
